poisson_spike_encoder: RTL and testbench



---
 rtl/poisson_spike_encoder_pkg.sv | 25 ++
 rtl/poisson_spike_encoder_if.sv | 40 ++++
 rtl/poisson_spike_encoder.sv | 183 ++++++++++++++++++
 tb/tb_poisson_spike_encoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poisson_spike_encoder_pkg.sv
// Shared definitions for the Poisson spike encoder.
// Contents:
//   LFSR_W     - width of the external LFSR register value
//   state_t    - encoder FSM state encoding (3-bit)
//   rnd_slice  - extracts the random comparison value from the LFSR register
package poisson_spike_encoder_pkg;

  localparam int LFSR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CMP  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The random value is the top pix_w bits of the LFSR register, right-aligned
  // so it can be compared directly against an unsigned pixel intensity.
  function automatic logic [LFSR_W-1:0] rnd_slice(input logic [LFSR_W-1:0] lfsr_val,
                                                  input int unsigned pix_w);
    return lfsr_val >> (LFSR_W - pix_w);
  endfunction

endpackage

// File: rtl/poisson_spike_encoder_if.sv
// Bus bundle between the spike encoder and its neighbours.
// Groups three channels:
//   pixel read : pix_rd_en, pix_addr (encoder -> memory), pix_data (memory -> encoder, one cycle later)
//   lfsr       : lfsr_shift (encoder -> lfsr), lfsr_out (lfsr -> encoder)
//   spike out  : spike_valid, spike, spike_idx, spike_step, step_done (encoder -> neuron layer),
//                spike_ready (neuron layer -> encoder)
// Modports: master = encoder side, slave = environment side.
interface poisson_spike_encoder_if
  import poisson_spike_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 8,
  parameter int STEP_W = 8
);

  logic              pix_rd_en;
  logic [ADDR_W-1:0] pix_addr;
  logic [PIX_W-1:0]  pix_data;
  logic              lfsr_shift;
  logic [LFSR_W-1:0] lfsr_out;
  logic              spike_valid;
  logic              spike_ready;
  logic              spike;
  logic [ADDR_W-1:0] spike_idx;
  logic [STEP_W-1:0] spike_step;
  logic              step_done;

  modport master (
    output pix_rd_en, pix_addr, lfsr_shift,
    output spike_valid, spike, spike_idx, spike_step, step_done,
    input  pix_data, lfsr_out, spike_ready
  );

  modport slave (
    input  pix_rd_en, pix_addr, lfsr_shift,
    input  spike_valid, spike, spike_idx, spike_step, step_done,
    output pix_data, lfsr_out, spike_ready
  );

endinterface

// File: rtl/poisson_spike_encoder.sv
// Poisson (Bernoulli) rate encoder: for each of num_steps timesteps it reads
// every pixel, draws one value from an external LFSR and emits
// spike = (pixel > rnd) on a valid/ready stream.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start      - begin one frame (only honoured in IDLE)
//   num_steps  - timesteps per frame, latched on start
//   busy       - high whenever the FSM is not IDLE
//   done       - one-cycle pulse when the frame completes
//   bus        - master side of the pixel / lfsr / spike bundle
module poisson_spike_encoder
  import poisson_spike_encoder_pkg::*;
#(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int STEP_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [STEP_W-1:0]        num_steps,
  output logic                     busy,
  output logic                     done,
  poisson_spike_encoder_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] idx_r;
  logic [STEP_W-1:0] step_r;
  logic [STEP_W-1:0] steps_r;
  logic              spike_r;
  logic              pix_rd_en_r;
  logic              lfsr_shift_r;
  logic              spike_valid_r;
  logic              busy_r;
  logic              done_r;

  logic              hs_s;
  logic              last_idx_s;
  logic              last_step_s;
  logic [LFSR_W-1:0] rnd_s;
  logic [LFSR_W-1:0] pix_ext_s;
  logic              spike_next_s;

  assign hs_s         = spike_valid_r & bus.spike_ready;
  assign last_idx_s   = (idx_r == LAST_IDX);
  assign last_step_s  = (step_r == (steps_r - STEP_ONE));
  assign rnd_s        = rnd_slice(bus.lfsr_out, PIX_W);
  assign pix_ext_s    = LFSR_W'(bus.pix_data);
  assign spike_next_s = (pix_ext_s > rnd_s);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (num_steps == {STEP_W{1'b0}}) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_READ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_READ: next_state_s = ST_CMP;
      ST_CMP:  next_state_s = ST_EMIT;
      ST_EMIT: begin
        if (hs_s) begin
          if (last_idx_s && last_step_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_READ;
          end
        end else begin
          next_state_s = ST_EMIT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Moore outputs registered from the next state so they are glitch-free and
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_rd_en_r   <= 1'b0;
      lfsr_shift_r  <= 1'b0;
      spike_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      pix_rd_en_r   <= (next_state_s == ST_READ);
      lfsr_shift_r  <= (next_state_s == ST_CMP);
      spike_valid_r <= (next_state_s == ST_EMIT);
      busy_r        <= (next_state_s != ST_IDLE);
      done_r        <= (next_state_s == ST_DONE);
    end
  end

  // Pixel/step counters, latched step count and the registered spike bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {ADDR_W{1'b0}};
      step_r  <= {STEP_W{1'b0}};
      steps_r <= {STEP_W{1'b0}};
      spike_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            steps_r <= num_steps;
            if (num_steps != {STEP_W{1'b0}}) begin
              idx_r  <= {ADDR_W{1'b0}};
              step_r <= {STEP_W{1'b0}};
            end else begin
              idx_r  <= idx_r;
              step_r <= step_r;
            end
          end else begin
            steps_r <= steps_r;
          end
        end
        ST_CMP: begin
          // pix_data arrives this cycle; lfsr_out still holds the value
          // for this pixel because the shift takes effect at this edge.
          spike_r <= spike_next_s;
        end
        ST_EMIT: begin
          if (hs_s) begin
            if (last_idx_s) begin
              idx_r <= {ADDR_W{1'b0}};
              // On the final step the counter holds at steps_r-1.
              if (!last_step_s) begin
                step_r <= step_r + STEP_ONE;
              end else begin
                step_r <= step_r;
              end
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          spike_r <= spike_r;
        end
      endcase
    end
  end

  assign bus.pix_rd_en   = pix_rd_en_r;
  assign bus.pix_addr    = idx_r;
  assign bus.lfsr_shift  = lfsr_shift_r;
  assign bus.spike_valid = spike_valid_r;
  assign bus.spike       = spike_r;
  assign bus.spike_idx   = idx_r;
  assign bus.spike_step  = step_r;
  // step_done must coincide with the accepting handshake, so it is
  // decoded from registered terms rather than registered itself.
  assign bus.step_done   = hs_s & last_idx_s;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Self-checking bench for poisson_spike_encoder (NUM_PIXELS=4).
// A table of frame descriptions is applied in a loop; a scoreboard queue holds
// the spikes predicted from the pixel values and the lfsr sequence, and is
// popped on every accepted spike. Reset-in-frame is a hand-written sequence.
module tb_poisson_spike_encoder;

  localparam int NP = 4;
  localparam int PW = 8;
  localparam int AW = 3;
  localparam int SW = 8;

  typedef struct {
    int               steps;
    logic [3:0][7:0]  pix;
    logic [11:0][15:0] stub;
    bit               real_lfsr;
    int               stall;
  } row_t;

  typedef struct packed {
    logic          spike;
    logic [AW-1:0] idx;
    logic [SW-1:0] step;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] num_steps;
  logic          busy;
  logic          done;

  poisson_spike_encoder_if #(.ADDR_W(AW), .PIX_W(PW), .STEP_W(SW)) bus ();

  poisson_spike_encoder #(
    .NUM_PIXELS(NP), .PIX_W(PW), .ADDR_W(AW), .STEP_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [PW-1:0]     pix_mem [8];
  logic [11:0][15:0] cur_stub;
  bit                use_real;
  logic              stub_rst;
  int                stub_ptr;
  logic [15:0]       lfsr_reg;
  int                checks = 0;
  int                errs = 0;
  exp_t              exp_q[$];
  row_t              rows[5];

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // LFSR source: either a scripted stub sequence or a real Galois LFSR.
  always @(posedge clk) begin
    if (stub_rst) begin
      stub_ptr <= 0;
      lfsr_reg <= 16'hACE1;
    end else if (bus.lfsr_shift) begin
      stub_ptr <= stub_ptr + 1;
      lfsr_reg <= galois(lfsr_reg);
    end
  end

  assign bus.lfsr_out = use_real ? lfsr_reg : ((stub_ptr < 12) ? cur_stub[stub_ptr] : 16'h0000);

  // Pixel memory with one cycle read latency.
  always @(posedge clk) begin
    if (bus.pix_rd_en) bus.pix_data <= pix_mem[bus.pix_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setup(input row_t r);
    cur_stub = r.stub;
    use_real = r.real_lfsr;
    for (int i = 0; i < NP; i++) pix_mem[i] = r.pix[i];
    @(posedge clk); #1 stub_rst = 1'b1;
    @(posedge clk); #1 stub_rst = 1'b0;
  endtask

  task automatic run_frame(input row_t r);
    int k;
    logic [15:0] cur;
    logic [15:0] v;
    int n, shifts, rds, sds, dones, lat;
    bit got_done;
    exp_t e;
    setup(r);
    k = 0;
    cur = 16'hACE1;
    for (int s = 0; s < r.steps; s++) begin
      for (int p = 0; p < NP; p++) begin
        v = r.real_lfsr ? cur : ((k < 12) ? r.stub[k] : 16'h0000);
        cur = galois(cur);
        k++;
        e.spike = (r.pix[p] > v[15:8]);
        e.idx   = AW'(p);
        e.step  = SW'(s);
        exp_q.push_back(e);
      end
    end
    bus.spike_ready = 1'b1;
    start = 1'b1;
    num_steps = SW'(r.steps);
    @(posedge clk); #1 start = 1'b0;
    n = 0; shifts = 0; rds = 0; sds = 0; dones = 0; lat = 0; got_done = 1'b0;
    fork
      begin : monitor
        while (!got_done && n < 2000) begin
          @(negedge clk);
          n++;
          if (bus.lfsr_shift) shifts++;
          if (bus.pix_rd_en) rds++;
          if (bus.step_done) begin
            sds++;
            check("step_done_idx", 32'(bus.spike_idx), 32'(NP - 1));
          end
          if (bus.spike_valid && bus.spike_ready) begin
            if (exp_q.size() == 0) begin
              check("sb_extra_spike", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("spike", 32'(bus.spike), 32'(e.spike));
              check("spike_idx", 32'(bus.spike_idx), 32'(e.idx));
              check("spike_step", 32'(bus.spike_step), 32'(e.step));
            end
          end
          if (done) begin
            dones++;
            lat = n;
            got_done = 1'b1;
          end
        end
      end
      begin : poke
        if (r.steps != 0) begin
          repeat (4) @(posedge clk);
          #1 start = 1'b1;
          num_steps = SW'(7);
          @(posedge clk); #1 start = 1'b0;
          num_steps = SW'(r.steps);
        end
      end
      begin : stall
        if (r.stall != 0) begin
          int w;
          logic          s_spk;
          logic [AW-1:0] s_idx;
          logic [SW-1:0] s_stp;
          w = 0;
          do begin @(negedge clk); w++; end
          while (!(bus.pix_rd_en && bus.pix_addr == AW'(1)) && w < 200);
          @(posedge clk); #1 bus.spike_ready = 1'b0;
          w = 0;
          do begin @(negedge clk); w++; end while (!bus.spike_valid && w < 20);
          s_spk = bus.spike; s_idx = bus.spike_idx; s_stp = bus.spike_step;
          check("stall_idx_start", 32'(s_idx), 32'd1);
          for (int i = 1; i < r.stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.spike_valid), 32'd1);
            check("stall_stable", {23'd0, bus.spike, bus.spike_idx, bus.spike_step},
                  {23'd0, s_spk, s_idx, s_stp});
          end
          @(posedge clk); #1 bus.spike_ready = 1'b1;
        end
      end
    join
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", 32'(lat), 32'(3 * NP * r.steps + 1 + r.stall));
    check("lfsr_shift_count", 32'(shifts), 32'(NP * r.steps));
    check("pix_rd_count", 32'(rds), 32'(NP * r.steps));
    check("step_done_count", 32'(sds), 32'(r.steps));
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("done_count", 32'(dones), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int w;
    bit seen;
    rst = 1'b1; start = 1'b0; num_steps = '0; stub_rst = 1'b0;
    use_real = 1'b0; cur_stub = '0; bus.spike_ready = 1'b1;
    for (int i = 0; i < 8; i++) pix_mem[i] = '0;

    rows[0] = '{steps: 1, pix: {8'd128, 8'd128, 8'd255, 8'd0},
                stub: {128'h0, 16'h7F00, 16'h8000, 16'h0000, 16'h0000},
                real_lfsr: 1'b0, stall: 0};
    rows[1] = rows[0];
    rows[1].stall = 5;
    rows[2] = '{steps: 0, pix: {8'd9, 8'd9, 8'd9, 8'd9}, stub: '0, real_lfsr: 1'b0, stall: 0};
    rows[3] = '{steps: 3, pix: {8'd128, 8'd1, 8'd200, 8'd40},
                stub: {16'h8100, 16'h00FF, 16'hFF00, 16'h2800,
                       16'h7F00, 16'h0100, 16'hC700, 16'h2900,
                       16'h8000, 16'h0000, 16'hC800, 16'h1000},
                real_lfsr: 1'b0, stall: 0};
    rows[4] = '{steps: 1, pix: {8'd255, 8'd255, 8'd255, 8'd255}, stub: '0, real_lfsr: 1'b1, stall: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {22'd0, busy, done, bus.spike_valid, bus.lfsr_shift, bus.pix_rd_en,
           bus.spike, bus.step_done, 3'd0},
          32'd0);
    check("reset_idx_step", {21'd0, bus.spike_idx, bus.spike_step}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(rows[i]);

    // Reset while in the EMIT state of step 1.
    setup(rows[3]);
    start = 1'b1; num_steps = SW'(2);
    @(posedge clk); #1 start = 1'b0;
    w = 0; seen = 1'b0;
    while (!seen && w < 200) begin
      @(negedge clk);
      w++;
      seen = bus.spike_valid && (bus.spike_step == SW'(1));
    end
    check("reach_step1_emit", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1'b1; bus.spike_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.spike_valid), 32'd0);
    check("rst_shift", 32'(bus.lfsr_shift), 32'd0);
    @(posedge clk); #1 rst = 1'b0; bus.spike_ready = 1'b1;
    w = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) w++;
    end
    check("rst_no_done_no_restart", 32'(w), 32'd0);
    exp_q.delete();
    run_frame(rows[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
